// File: rtl/hyperram_pkg.sv
// Shared definitions for the HyperRAM port arbiter and its helpers.
//   ADDR_W / DATA_W / STRB_W : widths of the controller bus fields
//   state_t                  : arbiter FSM encoding (IDLE, WAIT)
package hyperram_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 16;
  localparam int STRB_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/hyperram_arbiter_rr_picker.sv
// rr_picker: combinational rotating priority encoder.
// Ports:
//   pend  in  NPORTS  candidate request bits
//   rr    in  IDXW    last served index; search starts at rr+1, rr is last
//   valid out 1       at least one candidate present
//   idx   out IDXW    chosen index (meaningful only when valid=1)
module rr_picker #(
  parameter int NPORTS = 2,
  parameter int IDXW   = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
  input  logic [NPORTS-1:0] pend,
  input  logic [IDXW-1:0]   rr,
  output logic              valid,
  output logic [IDXW-1:0]   idx
);

  logic [NPORTS-1:0] rot;
  int                step;
  int                sum;

  always_comb begin
    // Rotate so that bit 0 of rot corresponds to port rr+1 (mod NPORTS).
    rot   = NPORTS'({pend, pend} >> (int'(rr) + 1));
    valid = |rot;
    step  = 0;
    // Descending scan: the lowest set rotated bit wins.
    for (int k = NPORTS - 1; k >= 0; k--) begin
      if (rot[k]) step = k;
    end
    sum = int'(rr) + 1 + step;
    if (sum >= NPORTS) sum = sum - NPORTS;
    idx = IDXW'(sum);
  end

endmodule

// File: rtl/hyperram_arbiter.sv
// hyperram_arbiter: shares the HyperRAM controller toggle-handshake port
// between NPORTS requesters with round-robin grant and optional lock.
//
// Handshake: every port (and the controller link) uses toggle req/ack.
// A request is outstanding while req != ack; the responder completes it by
// making ack equal to req again. The requester must hold its fields stable
// until its own ack toggles.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   req/ack                     per-port request/acknowledge toggles
//   lock                        per-port ownership hold
//   as/we/linear_burst/a/d/ds   per-port transaction fields
//   q                           per-port registered read data
//   mem_req/mem_ack             controller request/acknowledge toggles
//   mem_as/we/linear_burst/a/d/ds  forwarded transaction fields
//   mem_q                       controller read data
//   busy                        transaction outstanding at the controller
//   owner                       last or current granted port
//   fsm_state                   FSM state, for observation
module hyperram_arbiter
  import hyperram_pkg::*;
#(
  parameter int NPORTS = 2,
  parameter int IDXW   = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NPORTS-1:0]        req,
  output logic [NPORTS-1:0]        ack,
  input  logic [NPORTS-1:0]        lock,
  input  logic [NPORTS-1:0]        as,
  input  logic [NPORTS-1:0]        we,
  input  logic [NPORTS-1:0]        linear_burst,
  input  logic [ADDR_W*NPORTS-1:0] a,
  input  logic [DATA_W*NPORTS-1:0] d,
  input  logic [STRB_W*NPORTS-1:0] ds,
  output logic [DATA_W*NPORTS-1:0] q,
  output logic                     mem_req,
  input  logic                     mem_ack,
  output logic                     mem_as,
  output logic                     mem_we,
  output logic                     mem_linear_burst,
  output logic [ADDR_W-1:0]        mem_a,
  output logic [DATA_W-1:0]        mem_d,
  output logic [STRB_W-1:0]        mem_ds,
  input  logic [DATA_W-1:0]        mem_q,
  output logic                     busy,
  output logic [IDXW-1:0]          owner,
  output state_t                   fsm_state
);

  logic [NPORTS-1:0] pend;
  logic [NPORTS-1:0] eligible;
  logic [IDXW-1:0]   rr;
  logic              has_grant;
  logic              locked;
  logic              pick_valid;
  logic [IDXW-1:0]   pick_idx;

  assign pend = req ^ ack;

  // Lock only applies once owner really refers to a past grant.
  assign locked = has_grant && lock[owner];

  always_comb begin
    eligible = pend;
    if (locked) eligible = pend & (NPORTS'(1) << owner);
  end

  rr_picker #(
    .NPORTS (NPORTS),
    .IDXW   (IDXW)
  ) u_picker (
    .pend  (eligible),
    .rr    (rr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ack              <= '0;
      q                <= '0;
      mem_req          <= 1'b0;
      mem_as           <= 1'b0;
      mem_we           <= 1'b0;
      mem_linear_burst <= 1'b0;
      mem_a            <= '0;
      mem_d            <= '0;
      mem_ds           <= '0;
      busy             <= 1'b0;
      owner            <= '0;
      rr               <= '0;
      has_grant        <= 1'b0;
      fsm_state        <= IDLE;
    end else begin
      case (fsm_state)
        IDLE: begin
          if (pick_valid) begin
            owner            <= pick_idx;
            has_grant        <= 1'b1;
            mem_as           <= as[pick_idx];
            mem_we           <= we[pick_idx];
            mem_linear_burst <= linear_burst[pick_idx];
            mem_a            <= a[pick_idx*ADDR_W +: ADDR_W];
            mem_d            <= d[pick_idx*DATA_W +: DATA_W];
            mem_ds           <= ds[pick_idx*STRB_W +: STRB_W];
            mem_req          <= ~mem_req;
            busy             <= 1'b1;
            fsm_state        <= WAIT;
          end
        end
        WAIT: begin
          // Completion; q is copied on writes too (value is don't-care).
          if (mem_ack == mem_req) begin
            q[owner*DATA_W +: DATA_W] <= mem_q;
            ack[owner]                <= ~ack[owner];
            busy                      <= 1'b0;
            rr                        <= owner;
            fsm_state                 <= IDLE;
          end
        end
        default: fsm_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hyperram_arbiter.sv
// Self-checking bench for hyperram_arbiter (NPORTS=2) with a behavioural
// HyperRAM controller of programmable latency.
module tb_hyperram_arbiter;
  import hyperram_pkg::*;

  localparam int NPORTS = 2;
  localparam int IDXW   = 1;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [NPORTS-1:0]        req = '0;
  logic [NPORTS-1:0]        ack;
  logic [NPORTS-1:0]        lock = '0;
  logic [NPORTS-1:0]        as = '0;
  logic [NPORTS-1:0]        we = '0;
  logic [NPORTS-1:0]        linear_burst = '0;
  logic [32*NPORTS-1:0]     a = '0;
  logic [16*NPORTS-1:0]     d = '0;
  logic [2*NPORTS-1:0]      ds = '0;
  logic [16*NPORTS-1:0]     q;
  logic                     mem_req;
  logic                     mem_ack = 1'b0;
  logic                     mem_as, mem_we, mem_linear_burst;
  logic [31:0]              mem_a;
  logic [15:0]              mem_d;
  logic [1:0]               mem_ds;
  logic [15:0]              mem_q = 16'h0000;
  logic                     busy;
  logic [IDXW-1:0]          owner;
  state_t                   fsm_state;

  hyperram_arbiter #(.NPORTS(NPORTS)) dut (
    .clk(clk), .reset(reset), .req(req), .ack(ack), .lock(lock), .as(as),
    .we(we), .linear_burst(linear_burst), .a(a), .d(d), .ds(ds), .q(q),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_as(mem_as), .mem_we(mem_we),
    .mem_linear_burst(mem_linear_burst), .mem_a(mem_a), .mem_d(mem_d),
    .mem_ds(mem_ds), .mem_q(mem_q), .busy(busy), .owner(owner),
    .fsm_state(fsm_state)
  );

  // ---------------- controller model ----------------
  logic [15:0] mem_model [logic [31:0]];
  int mem_lat = 1;
  int lat_cnt = 0;
  int cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      mem_ack <= 1'b0;
      lat_cnt <= 0;
    end else if (mem_req != mem_ack) begin
      if (lat_cnt >= mem_lat - 1) begin
        mem_ack <= ~mem_ack;
        lat_cnt <= 0;
        if (mem_we) mem_model[mem_a] = mem_d;
        else mem_q <= mem_model.exists(mem_a) ? mem_model[mem_a] : 16'hDEAD;
      end else begin
        lat_cnt <= lat_cnt + 1;
      end
    end
  end

  // ---------------- grant monitor ----------------
  logic            last_req = 1'b0;
  logic [IDXW-1:0] grant_log[$];
  int              grant_cyc[$];
  logic [IDXW-1:0] exp_q[$];

  always @(posedge clk) begin
    #1;
    if (reset) begin
      last_req = mem_req;
    end else if (mem_req !== last_req) begin
      last_req = mem_req;
      grant_log.push_back(owner);
      grant_cyc.push_back(cyc);
    end
  end

  int total = 0;
  int bad = 0;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req   = '0;
    lock  = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    grant_log.delete();
    grant_cyc.delete();
  endtask

  task automatic issue(input logic [IDXW-1:0] p, input logic s, input logic w,
                       input logic lb, input logic [31:0] addr,
                       input logic [15:0] data, input logic [1:0] strobe);
    as[p]           = s;
    we[p]           = w;
    linear_burst[p] = lb;
    a[32*p +: 32]   = addr;
    d[16*p +: 16]   = data;
    ds[2*p +: 2]    = strobe;
    req[p]          = ~req[p];
  endtask

  task automatic wait_ack(input logic [IDXW-1:0] p, input int budget,
                          output int n, output bit ok);
    logic prev;
    prev = ack[p];
    n = 0;
    ok = 1'b0;
    while (!ok && n < budget) begin
      @(negedge clk);
      n++;
      if (ack[p] !== prev) ok = 1'b1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    total++; if (ack !== 2'b00) begin bad++; $display("FAIL reset_ack: got %h want 0", ack); end
    total++; if (q !== 32'h0) begin bad++; $display("FAIL reset_q: got %h want 0", q); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    total++; if ({mem_as, mem_we, mem_linear_burst} !== 3'b000) begin bad++; $display("FAIL reset_mem_ctl: got %b want 000", {mem_as, mem_we, mem_linear_burst}); end
    total++; if ({mem_a, mem_d, mem_ds} !== 50'h0) begin bad++; $display("FAIL reset_mem_fields: got %h want 0", {mem_a, mem_d, mem_ds}); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (owner !== 1'b0) begin bad++; $display("FAIL reset_owner: got %h want 0", owner); end
    total++; if (fsm_state !== IDLE) begin bad++; $display("FAIL reset_state: got %0d want IDLE", fsm_state); end
  endtask

  task automatic test_single_write();
    int n; bit ok;
    issue(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 16'hBEEF, 2'b11);
    @(negedge clk);
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL wr_mem_req: got %b want 1", mem_req); end
    total++; if (mem_a !== 32'h100) begin bad++; $display("FAIL wr_mem_a: got %h want 100", mem_a); end
    total++; if (mem_d !== 16'hBEEF) begin bad++; $display("FAIL wr_mem_d: got %h want beef", mem_d); end
    total++; if (mem_ds !== 2'b11) begin bad++; $display("FAIL wr_mem_ds: got %b want 11", mem_ds); end
    total++; if ({mem_as, mem_we, mem_linear_burst} !== 3'b011) begin bad++; $display("FAIL wr_mem_ctl: got %b want 011", {mem_as, mem_we, mem_linear_burst}); end
    total++; if (busy !== 1'b1 || fsm_state !== WAIT) begin bad++; $display("FAIL wr_busy: got %b/%0d want 1/WAIT", busy, fsm_state); end
    wait_ack(1'b0, 20, n, ok);
    total++; if (!ok || n != 2) begin bad++; $display("FAIL wr_ack_latency: got ok=%0d n=%0d want ok=1 n=2", ok, n); end
    total++; if (ack !== 2'b01) begin bad++; $display("FAIL wr_ack: got %b want 01", ack); end
    total++; if (mem_ack !== mem_req || busy !== 1'b0) begin bad++; $display("FAIL wr_done: got mem_ack=%b mem_req=%b busy=%b want match,0", mem_ack, mem_req, busy); end
  endtask

  task automatic test_single_read();
    int n; bit ok;
    mem_model[32'h0000_2000] = 16'h1234;
    issue(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_2000, 16'h0000, 2'b11);
    @(negedge clk);
    total++; if (owner !== 1'b1 || mem_a !== 32'h2000) begin bad++; $display("FAIL rd_grant: got owner=%h a=%h want 1/2000", owner, mem_a); end
    total++; if ({mem_as, mem_we} !== 2'b10) begin bad++; $display("FAIL rd_ctl: got %b want 10", {mem_as, mem_we}); end
    total++; if (q[31:16] !== 16'h0000) begin bad++; $display("FAIL rd_q_early: got %h want 0", q[31:16]); end
    wait_ack(1'b1, 20, n, ok);
    total++; if (!ok || n != 2) begin bad++; $display("FAIL rd_ack_latency: got ok=%0d n=%0d want ok=1 n=2", ok, n); end
    total++; if (q[31:16] !== 16'h1234) begin bad++; $display("FAIL rd_q: got %h want 1234", q[31:16]); end
    total++; if (ack !== 2'b11) begin bad++; $display("FAIL rd_ack: got %b want 11", ack); end
  endtask

  task automatic test_round_robin();
    int n; bit ok;
    logic [IDXW-1:0] e;
    do_reset();
    exp_q.delete();
    for (int r = 0; r < 4; r++) begin
      issue(1'b0, 1'b0, 1'b1, 1'b0, 32'h1000 + r, 16'h0A00 + 16'(r), 2'b01);
      issue(1'b1, 1'b0, 1'b1, 1'b0, 32'h2100 + r, 16'h0B00 + 16'(r), 2'b10);
      exp_q.push_back(1'b1);
      exp_q.push_back(1'b0);
      wait_ack(1'b1, 30, n, ok);
      total++; if (!ok) begin bad++; $display("FAIL rr_ack1: got timeout want ack round %0d", r); end
      wait_ack(1'b0, 30, n, ok);
      total++; if (!ok) begin bad++; $display("FAIL rr_ack0: got timeout want ack round %0d", r); end
    end
    total++; if (grant_log.size() != 8) begin bad++; $display("FAIL rr_count: got %0d want 8", grant_log.size()); end
    for (int i = 0; i < 8 && grant_log.size() > 0; i++) begin
      e = exp_q.pop_front();
      total++; if (grant_log[0] !== e) begin bad++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, grant_log[0], e); end
      if (i > 0) begin
        total++; if (grant_cyc[1] - grant_cyc[0] < 2) begin bad++; $display("FAIL rr_bubble[%0d]: got gap %0d want >=2", i, grant_cyc[1] - grant_cyc[0]); end
        void'(grant_cyc.pop_front());
      end
      void'(grant_log.pop_front());
    end
  endtask

  task automatic test_lock();
    int n; bit ok;
    int ack_cyc;
    grant_log.delete();
    grant_cyc.delete();
    lock[0] = 1'b1;
    issue(1'b0, 1'b0, 1'b0, 1'b1, 32'h3000, 16'h0, 2'b11);
    @(negedge clk);
    issue(1'b1, 1'b0, 1'b0, 1'b1, 32'h4000, 16'h0, 2'b11);
    ack_cyc = 0;
    for (int k = 0; k < 3; k++) begin
      wait_ack(1'b0, 30, n, ok);
      total++; if (!ok) begin bad++; $display("FAIL lock_ack0[%0d]: got timeout want ack", k); end
      if (k < 2) issue(1'b0, 1'b0, 1'b0, 1'b1, 32'h3001 + k, 16'h0, 2'b11);
      else begin
        lock[0] = 1'b0;
        ack_cyc = cyc;
      end
    end
    wait_ack(1'b1, 30, n, ok);
    total++; if (!ok) begin bad++; $display("FAIL lock_ack1: got timeout want ack"); end
    total++; if (grant_log.size() != 4) begin bad++; $display("FAIL lock_count: got %0d want 4", grant_log.size()); end
    else begin
      total++; if ({grant_log[0], grant_log[1], grant_log[2], grant_log[3]} !== 4'b0001) begin bad++; $display("FAIL lock_order: got %b want 0001", {grant_log[0], grant_log[1], grant_log[2], grant_log[3]}); end
      total++; if (grant_cyc[3] != ack_cyc + 1) begin bad++; $display("FAIL lock_release: got cycle %0d want %0d", grant_cyc[3], ack_cyc + 1); end
    end
  endtask

  task automatic test_reset_mid();
    int n; bit ok;
    mem_lat = 20;
    issue(1'b0, 1'b0, 1'b1, 1'b0, 32'h5000, 16'h5555, 2'b11);
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy: got %b want 1", busy); end
    reset = 1'b1;
    req   = '0;
    lock  = '0;
    @(negedge clk);
    total++; if (ack !== 2'b00 || mem_req !== 1'b0) begin bad++; $display("FAIL mid_ack_req: got ack=%b mem_req=%b want 00/0", ack, mem_req); end
    total++; if (busy !== 1'b0 || q !== 32'h0) begin bad++; $display("FAIL mid_busy_q: got busy=%b q=%h want 0/0", busy, q); end
    total++; if (fsm_state !== IDLE || owner !== 1'b0) begin bad++; $display("FAIL mid_state: got %0d/%0d want IDLE/0", fsm_state, owner); end
    reset   = 1'b0;
    mem_lat = 1;
    issue(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_2000, 16'h0, 2'b11);
    wait_ack(1'b1, 20, n, ok);
    total++; if (!ok || n != 3) begin bad++; $display("FAIL mid_after: got ok=%0d n=%0d want ok=1 n=3", ok, n); end
    total++; if (q[31:16] !== 16'h1234 || ack !== 2'b10) begin bad++; $display("FAIL mid_after_q: got q=%h ack=%b want 1234/10", q[31:16], ack); end
  endtask

  task automatic test_long_latency();
    int n; bit ok; bit done;
    logic prev;
    mem_lat = 40;
    grant_log.delete();
    grant_cyc.delete();
    issue(1'b0, 1'b0, 1'b1, 1'b0, 32'hCAFE_0010, 16'h7E57, 2'b01);
    prev = ack[0];
    @(negedge clk);
    issue(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_2000, 16'h0, 2'b11);
    n = 0;
    done = 1'b0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
      total++; if ({mem_a, mem_d, mem_ds} !== {32'hCAFE_0010, 16'h7E57, 2'b01}) begin bad++; $display("FAIL long_stable[%0d]: got %h/%h/%b want cafe0010/7e57/01", n, mem_a, mem_d, mem_ds); end
      total++; if (grant_log.size() != 1) begin bad++; $display("FAIL long_single_req[%0d]: got %0d want 1", n, grant_log.size()); end
      if (ack[0] !== prev) done = 1'b1;
    end
    total++; if (!done || n != 41) begin bad++; $display("FAIL long_latency: got done=%0d n=%0d want 1/41", done, n); end
    wait_ack(1'b1, 60, n, ok);
    total++; if (!ok || q[31:16] !== 16'h1234) begin bad++; $display("FAIL long_port1: got ok=%0d q=%h want 1/1234", ok, q[31:16]); end
    total++; if (grant_log.size() != 2) begin bad++; $display("FAIL long_count: got %0d want 2", grant_log.size()); end
    mem_lat = 1;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_round_robin();
    test_lock();
    test_reset_mid();
    test_long_latency();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
